cpu_bus_responder: RTL and testbench

Bus-side responder for the 6502 core: the block that answers the CPU's address/data/R_nW transactions. It provides:

- the 2 KB internal work RAM, with its mirrors;
- the PRG ROM window, through an external combinational ROM port;
- the two serial controller ports at $4016/$4017;
- open-bus behaviour for every unmapped address.

It sits directly between the CPU core and the cartridge and pad inputs. Port names follow the CPU's point of view, so Data_bus_in is driven by this block.

---
 rtl/nes_bus_pkg.sv | 35 +++
 rtl/pad_shift.sv | 28 ++
 rtl/cpu_bus_responder.sv | 86 ++++++++
 tb/tb_cpu_bus_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared address map, button indices and region decode for the CPU bus responder.
// Used by cpu_bus_responder (optional controller 2 via PAD2_EN) and pad_shift.
package nes_bus_pkg;

    localparam logic [15:0] RAM_END   = 16'h1FFF;
    localparam logic [15:0] PAD1_ADDR = 16'h4016;
    localparam logic [15:0] PAD2_ADDR = 16'h4017;
    localparam logic [15:0] PRG_BASE  = 16'h8000;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_PRG,
        RGN_PAD1,
        RGN_PAD2,
        RGN_OPEN
    } region_e;

    function automatic region_e decode_region(input logic [15:0] addr);
        if (addr <= RAM_END)        return RGN_RAM;
        else if (addr >= PRG_BASE)  return RGN_PRG;
        else if (addr == PAD1_ADDR) return RGN_PAD1;
        else if (addr == PAD2_ADDR) return RGN_PAD2;
        else                        return RGN_OPEN;
    endfunction

endpackage

// File: rtl/pad_shift.sv
// Serial controller port: reloads from the buttons while strobed, otherwise
// shifts one bit per read of its own address, filling with 1s from the top.
module pad_shift
    import nes_bus_pkg::*;
(
    input  logic       clk_ph2,
    input  logic       rst,
    input  logic       strobe,
    input  logic       shift,
    input  logic [7:0] buttons,
    output logic       serial
);

    logic [7:0] sr;

    always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst)
            sr <= 8'h00;
        else if (strobe)
            sr <= buttons;
        else if (shift)
            sr <= {1'b1, sr[7:1]};
    end

    // While strobed the port is transparent to the live A button.
    assign serial = strobe ? buttons[BTN_A] : sr[0];

endmodule

// File: rtl/cpu_bus_responder.sv
// 6502 bus responder: 2 KB mirrored work RAM, PRG ROM window, $4016/$4017 pads, open bus.
// Define PAD2_EN to populate controller 2 at $4017; otherwise $4017 is open bus.
module cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter bit PRG_16K = 1'b0
) (
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic [15:0] Addr_bus,
    input  logic        R_nW,
    input  logic [7:0]  Data_bus_out,
    output logic [7:0]  Data_bus_in,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data,
    input  logic [7:0]  pad1_buttons,
    input  logic [7:0]  pad2_buttons
);

    logic [7:0] ram [0:2047];
    logic [7:0] ob;
    logic       strobe;
    logic       pad1_ser;
    region_e    rgn;

    assign rgn      = decode_region(Addr_bus);
    // A 16 KB image appears twice across $8000-$FFFF.
    assign prg_addr = {Addr_bus[14] & ~PRG_16K, Addr_bus[13:0]};

    pad_shift u_pad1 (
        .clk_ph2 (clk_ph2),
        .rst     (rst),
        .strobe  (strobe),
        .shift   (R_nW && (rgn == RGN_PAD1)),
        .buttons (pad1_buttons),
        .serial  (pad1_ser)
    );

`ifdef PAD2_EN
    logic pad2_ser;

    pad_shift u_pad2 (
        .clk_ph2 (clk_ph2),
        .rst     (rst),
        .strobe  (strobe),
        .shift   (R_nW && (rgn == RGN_PAD2)),
        .buttons (pad2_buttons),
        .serial  (pad2_ser)
    );
`else
    logic unused_pad2;
    assign unused_pad2 = ^pad2_buttons;
`endif

    always_comb begin
        Data_bus_in = ob;
        case (rgn)
            RGN_RAM:  Data_bus_in = ram[Addr_bus[10:0]];
            RGN_PRG:  Data_bus_in = prg_data;
            RGN_PAD1: Data_bus_in = {ob[7:5], 4'b0000, pad1_ser};
`ifdef PAD2_EN
            RGN_PAD2: Data_bus_in = {ob[7:5], 4'b0000, pad2_ser};
`endif
            default:  ;
        endcase
    end

    // Open-bus latch tracks whatever was last on the data bus, either direction.
    always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst) begin
            ob     <= 8'h00;
            strobe <= 1'b0;
        end else begin
            ob <= R_nW ? Data_bus_in : Data_bus_out;
            if (!R_nW && (rgn == RGN_PAD1))
                strobe <= Data_bus_out[0];
        end
    end

    // Work RAM keeps its contents through reset.
    always_ff @(posedge clk_ph2) begin
        if (!R_nW && (rgn == RGN_RAM))
            ram[Addr_bus[10:0]] <= Data_bus_out;
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboarded bench for cpu_bus_responder: directed map/pad/reset cases plus random traffic.
// Honors PAD2_EN the same way the design does.
module tb_cpu_bus_responder;

    logic        clk_ph2 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr_bus = 16'h5000;
    logic        R_nW = 1'b1;
    logic [7:0]  Data_bus_out = 8'h00;
    logic [7:0]  pad1_buttons = 8'h00;
    logic [7:0]  pad2_buttons = 8'h00;
    logic [7:0]  Data_bus_in, unused_db16, prg_data, prg_data16;
    logic [14:0] prg_addr, prg_addr16;

    always #5 clk_ph2 = ~clk_ph2;

    function automatic logic [7:0] rom(input logic [14:0] pa);
        return pa[7:0] ^ {pa[14:8], 1'b1};
    endfunction

    assign prg_data   = rom(prg_addr);
    assign prg_data16 = rom(prg_addr16);

    cpu_bus_responder #(.PRG_16K(1'b0)) dut (
        .clk_ph2(clk_ph2), .rst(rst), .Addr_bus(Addr_bus), .R_nW(R_nW),
        .Data_bus_out(Data_bus_out), .Data_bus_in(Data_bus_in), .prg_addr(prg_addr),
        .prg_data(prg_data), .pad1_buttons(pad1_buttons), .pad2_buttons(pad2_buttons)
    );

    cpu_bus_responder #(.PRG_16K(1'b1)) dut16 (
        .clk_ph2(clk_ph2), .rst(rst), .Addr_bus(Addr_bus), .R_nW(R_nW),
        .Data_bus_out(Data_bus_out), .Data_bus_in(unused_db16), .prg_addr(prg_addr16),
        .prg_data(prg_data16), .pad1_buttons(pad1_buttons), .pad2_buttons(pad2_buttons)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [14:0] pa;
        logic [14:0] pa16;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    // Reference model: RAM image, bus byte, strobe, and per-pad "bits read since latch".
    logic [7:0] m_ram [2048];
    logic [7:0] m_ob = 8'h00;
    logic       m_strobe = 1'b0;
    logic [7:0] m_lat1 = 8'h00;
    int         m_cnt1 = 0;
`ifdef PAD2_EN
    logic [7:0] m_lat2 = 8'h00;
    int         m_cnt2 = 0;
`endif

    function automatic logic pad_bit(input logic strb, input logic [7:0] live,
                                     input logic [7:0] lat, input int cnt);
        if (strb)     return live[0];
        if (cnt >= 8) return 1'b1;
        return lat[cnt[2:0]];
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        if (a < 16'h2000)  return m_ram[a[10:0]];
        if (a >= 16'h8000) return rom(a[14:0]);
        if (a == 16'h4016) return {m_ob[7:5], 4'b0000, pad_bit(m_strobe, pad1_buttons, m_lat1, m_cnt1)};
`ifdef PAD2_EN
        if (a == 16'h4017) return {m_ob[7:5], 4'b0000, pad_bit(m_strobe, pad2_buttons, m_lat2, m_cnt2)};
`endif
        return m_ob;
    endfunction

    task automatic commit(input logic [15:0] a, input logic r, input logic [7:0] d, input logic [7:0] rv);
        logic old_strobe;
        old_strobe = m_strobe;
        if (!r && a < 16'h2000) m_ram[a[10:0]] = d;
        m_ob = r ? rv : d;
        if (old_strobe) begin
            m_lat1 = pad1_buttons; m_cnt1 = 0;
        end else if (r && a == 16'h4016 && m_cnt1 < 8) m_cnt1++;
`ifdef PAD2_EN
        if (old_strobe) begin
            m_lat2 = pad2_buttons; m_cnt2 = 0;
        end else if (r && a == 16'h4017 && m_cnt2 < 8) m_cnt2++;
`endif
        if (!r && a == 16'h4016) m_strobe = d[0];
    endtask

    // One bus cycle; entered and left 2 time units after a rising edge.
    task automatic cyc_x(input logic [15:0] a, input logic r, input logic [7:0] d,
                         input bit has_exp, input logic [7:0] exp_d);
        exp_t e;
        logic [7:0] rv;
        Addr_bus = a; R_nW = r; Data_bus_out = d;
        rv = m_read(a);
        if (r) begin
            e.a = a; e.d = has_exp ? exp_d : rv;
            e.pa = a[14:0]; e.pa16 = {1'b0, a[13:0]};
            q.push_back(e);
        end
        @(posedge clk_ph2);
        commit(a, r, d, rv);
        #2;
    endtask

    task automatic cyc(input logic [15:0] a, input logic r, input logic [7:0] d);
        cyc_x(a, r, d, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc_x(a, 1'b0, d, 1'b0, 8'h00);
    endtask

    task automatic rd_exp(input logic [15:0] a, input logic [7:0] exp_d);
        cyc_x(a, 1'b1, 8'h00, 1'b1, exp_d);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        Addr_bus = 16'h5000; R_nW = 1'b1;
        rst = 1'b1;
        #20;
        m_ob = 8'h00; m_strobe = 1'b0; m_lat1 = 8'h00; m_cnt1 = 0;
`ifdef PAD2_EN
        m_lat2 = 8'h00; m_cnt2 = 0;
`endif
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic check(input string nm, input logic [15:0] a, input logic [15:0] act, input logic [15:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s addr=%h got=%h expected=%h t=%0t", nm, a, act, exp_v, $time);
        end
    endtask

    always @(negedge clk_ph2) begin
        exp_t e;
        if (mon_en && R_nW) begin
            if (q.size() == 0) begin
                check("sb_empty", Addr_bus, 16'(q.size()), 16'd1);
            end else begin
                e = q.pop_front();
                check("rdata", e.a, {8'h00, Data_bus_in}, {8'h00, e.d});
                check("prg_addr", e.a, {1'b0, prg_addr}, {1'b0, e.pa});
                check("prg_addr16", e.a, {1'b0, prg_addr16}, {1'b0, e.pa16});
            end
        end
    end

    initial begin
        logic [7:0] seq [10];
        seq = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
        @(posedge clk_ph2); #2;
        do_reset();

        // Reset state
        rd_exp(16'h5000, 8'h00);
        rd_exp(16'h4016, 8'h00);
        rd_exp(16'h4017, 8'h00);

        for (int i = 0; i < 2048; i++) wr(16'(i), 8'(i) ^ 8'h5A);

        // RAM mirrors
        wr(16'h0123, 8'hA5);
        rd_exp(16'h0923, 8'hA5);
        rd_exp(16'h1123, 8'hA5);
        rd_exp(16'h1923, 8'hA5);
        rd_exp(16'h0124, 8'h7E);

        // PRG window, 16K aliasing, writes ignored
        rd_exp(16'h8000, rom(15'h0000));
        rd_exp(16'hFFFC, rom(15'h7FFC));
        wr(16'h8000, 8'hFF);
        rd_exp(16'h8000, rom(15'h0000));
        rd_exp(16'hC123, rom(15'h4123));

        // Controller serial read-out
        pad1_buttons = 8'b1000_0101;
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        wr(16'h5000, 8'h40);
        for (int i = 0; i < 10; i++) rd_exp(16'h4016, seq[i]);

        // Strobe held: live A bit, no shift
        wr(16'h4016, 8'h01);
        rd_exp(16'h4016, 8'h01);
        rd_exp(16'h4016, 8'h01);
        pad1_buttons = 8'h84;
        rd_exp(16'h4016, 8'h00);
        rd_exp(16'h4016, 8'h00);
        pad1_buttons = 8'h85;
        rd_exp(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        rd_exp(16'h4016, 8'h01);
        rd_exp(16'h4016, 8'h00);

        // Open bus
        wr(16'h0200, 8'h3C);
        rd_exp(16'h5000, 8'h3C);
        rd_exp(16'h5000, 8'h3C);

        // Reset in the middle of a read sequence
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 3; i++) cyc(16'h4016, 1'b1, 8'h00);
        do_reset();
        rd_exp(16'h5000, 8'h00);
        rd_exp(16'h4016, 8'h00);
        rd_exp(16'h0123, 8'hA5);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic        r;
            logic [7:0]  d;
            int          sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: a = 16'($urandom_range(0, 16'h1FFF));
                3, 4:    a = 16'($urandom_range(16'h8000, 16'hFFFF));
                5, 6:    a = 16'h4016;
                7:       a = 16'h4017;
                default: a = 16'($urandom_range(16'h2000, 16'h7FFF));
            endcase
            r = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (a == 16'h4016 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) pad1_buttons = 8'($urandom);
            if ($urandom_range(0, 7) == 0) pad2_buttons = 8'($urandom);
            cyc(a, r, d);
        end

        mon_en = 1'b0;
        repeat (3) @(posedge clk_ph2);
        check("sb_drain", 16'h0000, 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
